// File: rtl/freq_divide_meter_if.sv
// Bundle of measurement signals between a divided-clock source, the
// freq_divide_meter and whatever consumes its results.
// master: the meter (receives sig_in, drives the measurement results).
// slave : the environment (drives sig_in, observes the results).
interface freq_divide_meter_if #(
  parameter int W = 16
);
  logic         sig_in;
  logic [W-1:0] period_out;
  logic [W-1:0] high_out;
  logic         ratio_even;
  logic         meas_valid;
  logic         timeout;

  modport master (
    input  sig_in,
    output period_out,
    output high_out,
    output ratio_even,
    output meas_valid,
    output timeout
  );

  modport slave (
    output sig_in,
    input  period_out,
    input  high_out,
    input  ratio_even,
    input  meas_valid,
    input  timeout
  );
endinterface

// File: rtl/freq_divide_meter.sv
// freq_divide_meter: receive-side checker for a clock divider.
// Synchronises an asynchronous divided clock into clk, measures period and
// high time in clk cycles between consecutive rising edges, flags exact
// 50 % duty and declares loss of signal after TIMEOUT cycles without a rise.
module freq_divide_meter #(
  parameter int W       = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                clr,
  freq_divide_meter_if.master mif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT);
  localparam logic [W-1:0] CNT_ONE   = W'(1);

  // Synchroniser and edge-detect flops.
  logic s1, s2, s3;
  logic rise, fall;

  // FSM state and counters.
  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] hi_shadow_q, hi_shadow_d;
  logic [W-1:0] cnt_inc;
  logic         expired;

  // Registered results.
  logic [W-1:0] period_q, period_d;
  logic [W-1:0] high_q, high_d;
  logic         ratio_q, ratio_d;
  logic         valid_q, valid_d;
  logic         timeout_q, timeout_d;

  // Two-flop synchroniser for sig_in plus one flop of history for edges.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each flop take the previous
      // stage's old value; blocking here would collapse the chain into one flop.
      s1 <= mif.sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // The counter saturates instead of wrapping, and the timeout test uses >=,
  // so a fall landing exactly on TIMEOUT with TIMEOUT = 2^W-1 cannot lock up.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
  assign expired = (cnt_q >= TIMEOUT_W);

  // Next-state, counter and result logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_shadow_d = hi_shadow_q;
    period_d    = period_q;
    high_d      = high_q;
    ratio_d     = ratio_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          // First rise only opens a measurement; nothing is reported yet.
          state_d = HIGH;
          cnt_d   = CNT_ONE;
        end
      end

      HIGH: begin
        if (fall) begin
          hi_shadow_d = cnt_q;
          state_d     = LOW;
          cnt_d       = cnt_inc;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      LOW: begin
        if (rise) begin
          // A rise on the timeout cycle still completes the period.
          period_d  = cnt_q;
          high_d    = hi_shadow_q;
          ratio_d   = ({1'b0, cnt_q} == {hi_shadow_q, 1'b0});
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          state_d   = HIGH;
          cnt_d     = CNT_ONE;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and result registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_shadow_q <= '0;
      period_q    <= '0;
      high_q      <= '0;
      ratio_q     <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_shadow_q <= hi_shadow_d;
      period_q    <= period_d;
      high_q      <= high_d;
      ratio_q     <= ratio_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign mif.period_out = period_q;
  assign mif.high_out   = high_q;
  assign mif.ratio_even = ratio_q;
  assign mif.meas_valid = valid_q;
  assign mif.timeout    = timeout_q;

endmodule

// File: doc/freq_divide_meter.md
# freq_divide_meter

- Measures the clock divider output at the receiving end; the divider generates a divided clock, this block recovers what it received.
- Samples an asynchronous divided-clock input in the system clock domain and reports its period and high time in system-clock cycles.
- Flags whether the received waveform is an exact 50 % even division, and flags loss of signal.
- Sits beside the divider chain as a self-check and bring-up instrument.

## Interface
Parameters:
- W, 16: width of the period and high-time counters and outputs.
- TIMEOUT, 65535: clk cycles without a rising edge of sig_in before loss of signal is declared; must satisfy 4 ≤ TIMEOUT ≤ 2^W−1.

Ports:
- clk  input  1  system clock; all state on posedge.
- clr  input  1  reset, asynchronous, active-high.
- sig_in  input  1  divided clock under measurement, asynchronous to clk.
- period_out  output  W  clk cycles between the last two rising edges of sig_in.
- high_out  output  W  clk cycles sig_in was high within that period.
- ratio_even  output  1  1 when period_out == 2*high_out (exact 50 % duty).
- meas_valid  output  1  one-cycle pulse; the three outputs above updated this cycle.
- timeout  output  1  loss-of-signal flag, level.

## Operation
- Synchronizer:
  - Two flops s1, s2 followed by edge flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - All s* reset to 0.
- State machine:
  - States IDLE, HIGH, LOW; reset state is IDLE.
  - IDLE: cnt held at 0. On rise, go to HIGH with cnt <= 1. Fall is ignored.
  - HIGH: cnt <= cnt+1 each cycle. On fall, hi_shadow <= cnt and go to LOW with cnt <= cnt+1.
  - LOW:
    - cnt <= cnt+1 each cycle.
    - On rise: period_out <= cnt, high_out <= hi_shadow, ratio_even <= ({cnt} == {hi_shadow,1'b0}), meas_valid <= 1, timeout <= 0; stay in HIGH path with cnt <= 1.
    - Precisely: on rise go to HIGH.
  - Any state other than IDLE: if cnt == TIMEOUT and no edge occurs this cycle, then timeout <= 1, go to IDLE, cnt <= 0, and discard the partial measurement. Outputs keep their last values.
- Counting arithmetic:
  - cnt is W bits and never wraps; TIMEOUT ≤ 2^W−1 guarantees the timeout fires before overflow.
  - The ratio_even comparison is done at W+1 bits.
- The first rise after reset or after a timeout only starts a measurement. A full period must complete before the next meas_valid.
- Reset:
  - Outputs reset to period_out=0, high_out=0, ratio_even=0, meas_valid=0, timeout=0.
  - hi_shadow and cnt reset to 0.
  - Reset mid-measurement discards everything; no meas_valid is produced for the interrupted period.

## Timing
- meas_valid is high for exactly one clk cycle per completed period, and never on two consecutive cycles.
- Latency:
  - Edge E is the first clk posedge at which s1 samples sig_in high.
  - rise is asserted in the cycle after E+1.
  - The outputs and meas_valid are registered at posedge E+2 and are visible until E+3.
- period_out equals the number of clk posedges between consecutive rise detections. It is exact for a sig_in stable relative to clk; ±1 jitter is allowed for truly asynchronous sig_in.
- Minimum measurable waveform: high and low phases each ≥ 2 clk cycles. Shorter phases can be lost in the synchronizer, and behaviour is then undefined but must not lock up.
- A timeout and a rise in the same cycle: the rise wins and no timeout is declared.
- timeout rises one cycle after the cycle in which cnt == TIMEOUT. It clears on the next meas_valid, not on the first rise.

## Test plan
- Symmetric division: sig_in 8 clk high / 8 clk low, locked to clk, 5 periods.
  - No meas_valid after the first rise.
  - Then 4 pulses, each with period_out=16, high_out=8, ratio_even=1, timeout=0.
- Asymmetric waveform: 10 high / 6 low.
  - period_out=16, high_out=10, ratio_even=0.
  - Switching to 3 high / 3 low gives period_out=6, high_out=3, ratio_even=1 from the second period after the change.
- Loss of signal: TIMEOUT=100, run 8/8 periods, then hold sig_in low.
  - timeout=1 at 101 cycles after the last rise is detected; period_out and high_out stay at 16 and 8.
  - After sig_in restarts, timeout stays 1 through the first rise and clears with the meas_valid one period later.
- Stuck high: TIMEOUT=100, sig_in held high after a rise.
  - timeout asserts and the state returns to IDLE.
  - The next fall causes no output change.
- Reset mid-operation: assert clr for 3 cycles inside a LOW phase, asynchronously to clk.
  - All outputs read 0 immediately.
  - No meas_valid until one full period after the first rise that follows release.
- Asynchronous input: sig_in of period 16.3 clk with random phase, for 1000 periods.
  - Every meas_valid reports period_out ∈ {16,17}.
  - meas_valid is never high on adjacent cycles.
